// File: rtl/instr_encoder_loader.sv
// Field-level ARM instruction encoder that streams encoded words into imem.
// Optional legality checking on accept is enabled by defining ENCODER_CHECK_EN.
module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       src2,
  input  logic [23:0]       imm24,
  input  logic              last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  input  logic              imem_ack,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  state_t      state;
  logic        pending_last;
  logic [31:0] word;
  logic        reject;

  // Branches keep only the link bits of funct and carry the 24-bit offset.
  always_comb begin
    word = {cond, op, funct, rn, rd, src2};
    if (op == 2'b10)
      word = {cond, 2'b10, funct[5:4], imm24};
  end

`ifdef ENCODER_CHECK_EN
  always_comb begin
    reject = 1'b0;
    if (op == 2'b11)
      reject = 1'b1;
    else if (op == 2'b00 && funct[4:3] == 2'b10 && !funct[0])
      reject = 1'b1;
    else if (op == 2'b10 && !funct[5])
      reject = 1'b1;
  end
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= BASE;
      imem_wd      <= '0;
      done         <= 1'b0;
      count        <= '0;
      error        <= 1'b0;
      pending_last <= 1'b0;
    end else if (start) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      imem_we   <= 1'b0;
      imem_addr <= BASE;
      done      <= 1'b0;
      count     <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (reject) begin
              // Rejected fields consume the accept slot but never reach memory.
              error <= 1'b1;
              if (last) begin
                state    <= DONE;
                done     <= 1'b1;
                in_ready <= 1'b0;
              end
            end else begin
              imem_wd      <= word;
              pending_last <= last;
              imem_we      <= 1'b1;
              in_ready     <= 1'b0;
              state        <= WRITE;
            end
          end
        end
        WRITE: begin
          if (imem_ack) begin
            imem_we <= 1'b0;
            count   <= count + (ADDR_W+1)'(1);
            if (imem_addr == TOP_ADDR) begin
              // Memory is full: stop without wrapping the address.
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              imem_addr <= imem_addr + ADDR_W'(1);
              if (pending_last) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                in_ready <= 1'b1;
                state    <= IDLE;
              end
            end
          end
        end
        DONE: begin
          in_ready <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          imem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
